// File: rtl/man_addsub_pipe.sv
// rtl/man_addsub_pipe.sv - two-stage mantissa adder/subtractor with valid/ready handshake
//
// Purpose:
//   Adds or subtracts two pre-aligned floating-point mantissas. The effective
//   operation is op ^ sign_a ^ sign_b. On an effective add the carry-out is
//   reported as o_overflow. On an effective subtract the block computes
//   max - min - carry and reports o_borrow when that result is negative.
//   Stage 1 registers the operands and the effective-operation bit.
//   Stage 2 registers the sum and its flags (and the leading-zero count).
//
// Ports:
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_flush                synchronous flush of both stage valids
//   i_valid / o_ready      upstream handshake
//   i_fpu_op               0 = add, 1 = subtract
//   i_sign_a, i_sign_b     operand signs
//   i_carry                borrow-in, only used on effective subtract
//   i_man_max, i_man_min   aligned mantissas (max has the larger magnitude)
//   o_valid / i_ready      downstream handshake
//   o_man_alu              result mantissa
//   o_overflow             carry-out of an effective add
//   o_borrow               effective subtract went negative
//   o_zero                 result mantissa and overflow are both zero
//   o_lzc                  leading zeros of o_man_alu (SIZE_MAN when zero)
//
// Configuration:
//   MAN_ADDSUB_LZC_EN      when defined, a stage-2 leading-zero counter drives
//                          o_lzc; otherwise o_lzc is tied to zero.

module man_addsub_pipe #(
  parameter int SIZE_MAN = 24,
  parameter int SIZE_LZC = $clog2(SIZE_MAN + 1)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_flush,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic                i_fpu_op,
  input  logic                i_sign_a,
  input  logic                i_sign_b,
  input  logic                i_carry,
  input  logic [SIZE_MAN-1:0] i_man_max,
  input  logic [SIZE_MAN-1:0] i_man_min,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [SIZE_MAN-1:0] o_man_alu,
  output logic                o_overflow,
  output logic                o_borrow,
  output logic                o_zero,
  output logic [SIZE_LZC-1:0] o_lzc
);

  // Stage 1 state
  logic                r_s1_valid;
  logic                r_s1_eff_sub;
  logic                r_s1_carry;
  logic [SIZE_MAN-1:0] r_s1_max;
  logic [SIZE_MAN-1:0] r_s1_min;

  // Stage 2 state
  logic                r_s2_valid;
  logic [SIZE_MAN-1:0] r_s2_man;
  logic                r_s2_ovf;
  logic                r_s2_bor;
  logic                r_s2_zero;

  logic                w_eff_sub;
  logic                w_s2_free;
  logic                w_s1_adv;
  logic                w_accept;
  logic                w_cin;
  logic [SIZE_MAN:0]   w_min_op;
  logic [SIZE_MAN:0]   w_sum;
  logic                w_ovf;
  logic                w_bor;
  logic                w_zero;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  assign w_eff_sub = i_fpu_op ^ i_sign_a ^ i_sign_b;

  // Stage 2 can take new data when it is empty or its result leaves this cycle.
  assign w_s2_free = ~r_s2_valid | i_ready;
  assign w_s1_adv  = r_s1_valid & w_s2_free;

  // Depends only on registered state and i_ready, never on i_valid.
  assign o_ready   = ~r_s1_valid | w_s1_adv;
  assign w_accept  = i_valid & o_ready;

  // ---------------------------------------------------------------------------
  // Stage 1: operand capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_valid   <= 1'b0;
      r_s1_eff_sub <= 1'b0;
      r_s1_carry   <= 1'b0;
      r_s1_max     <= '0;
      r_s1_min     <= '0;
    end else begin
      // When o_ready is high, stage 1 is either empty or draining, so its
      // next valid is simply whether something is accepted now.
      if (i_flush) begin
        r_s1_valid <= 1'b0;
      end else if (o_ready) begin
        r_s1_valid <= i_valid;
      end

      if (w_accept && !i_flush) begin
        r_s1_eff_sub <= w_eff_sub;
        r_s1_carry   <= i_carry;
        r_s1_max     <= i_man_max;
        r_s1_min     <= i_man_min;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Adder: subtract is max + ~min + ~carry, so carry-out high means no borrow.
  // ---------------------------------------------------------------------------
  assign w_cin    = r_s1_eff_sub & ~r_s1_carry;
  assign w_min_op = {1'b0, (r_s1_eff_sub ? ~r_s1_min : r_s1_min)};
  assign w_sum    = {1'b0, r_s1_max} + w_min_op + {{SIZE_MAN{1'b0}}, w_cin};

  assign w_ovf    = ~r_s1_eff_sub & w_sum[SIZE_MAN];
  assign w_bor    =  r_s1_eff_sub & ~w_sum[SIZE_MAN];
  assign w_zero   = (w_sum[SIZE_MAN-1:0] == '0) & ~w_ovf;

  // ---------------------------------------------------------------------------
  // Stage 2: result capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_man   <= '0;
      r_s2_ovf   <= 1'b0;
      r_s2_bor   <= 1'b0;
      r_s2_zero  <= 1'b1;
    end else begin
      if (i_flush) begin
        r_s2_valid <= 1'b0;
      end else if (w_s2_free) begin
        r_s2_valid <= r_s1_valid;
      end

      // Data only moves with a real item, so stalled outputs stay put.
      if (w_s1_adv && !i_flush) begin
        r_s2_man  <= w_sum[SIZE_MAN-1:0];
        r_s2_ovf  <= w_ovf;
        r_s2_bor  <= w_bor;
        r_s2_zero <= w_zero;
      end
    end
  end

  assign o_valid    = r_s2_valid;
  assign o_man_alu  = r_s2_man;
  assign o_overflow = r_s2_ovf;
  assign o_borrow   = r_s2_bor;
  assign o_zero     = r_s2_zero;

  // ---------------------------------------------------------------------------
  // Optional leading-zero counter on the stage-1 sum, registered in stage 2
  // ---------------------------------------------------------------------------
`ifdef MAN_ADDSUB_LZC_EN
  logic [SIZE_LZC-1:0] w_lzc;
  logic [SIZE_LZC-1:0] r_s2_lzc;

  // Scanning upward, the last set bit found is the most significant one.
  always_comb begin
    w_lzc = SIZE_LZC'(SIZE_MAN);
    for (int i = 0; i < SIZE_MAN; i++) begin
      if (w_sum[i]) begin
        w_lzc = SIZE_LZC'(SIZE_MAN - 1 - i);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s2_lzc <= '0;
    end else if (w_s1_adv && !i_flush) begin
      r_s2_lzc <= w_lzc;
    end
  end

  assign o_lzc = r_s2_lzc;
`else
  assign o_lzc = '0;
`endif

endmodule

// File: tb/tb_man_addsub_pipe.sv
// tb/tb_man_addsub_pipe.sv - self-checking bench for man_addsub_pipe
`timescale 1ns/1ps
module tb_man_addsub_pipe;
  localparam int N = 24;
  localparam int L = $clog2(N + 1);
`ifdef MAN_ADDSUB_LZC_EN
  localparam bit LZC = 1'b1;
`else
  localparam bit LZC = 1'b0;
`endif

  typedef struct packed {
    logic [N-1:0] man;
    logic         ovf;
    logic         bor;
    logic         zero;
    logic [L-1:0] lzc;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n, flush, valid, ready_in, op, sa, sb, carry;
  logic [N-1:0] mx, mn;
  logic         o_ready, o_valid, o_ovf, o_bor, o_zero;
  logic [N-1:0] o_man;
  logic [L-1:0] o_lzc;

  int   checks = 0;
  int   errors = 0;
  res_t q[$];
  logic acc, fire, cap_valid, cap_ready;
  res_t cap;

  always #5 clk = ~clk;

  man_addsub_pipe #(.SIZE_MAN(N), .SIZE_LZC(L)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(valid), .o_ready(o_ready),
    .i_fpu_op(op), .i_sign_a(sa), .i_sign_b(sb), .i_carry(carry),
    .i_man_max(mx), .i_man_min(mn), .o_valid(o_valid), .i_ready(ready_in),
    .o_man_alu(o_man), .o_overflow(o_ovf), .o_borrow(o_bor), .o_zero(o_zero), .o_lzc(o_lzc)
  );

  // Reference: signed integer arithmetic on the operand values.
  function automatic res_t model(logic fop, logic s_a, logic s_b, logic c,
                                 logic [N-1:0] a, logic [N-1:0] b);
    res_t   r;
    longint d;
    r = '0;
    if ((fop ^ s_a ^ s_b) == 1'b0) begin
      d     = longint'(a) + longint'(b);
      r.ovf = (d >= (longint'(1) << N));
    end else begin
      d     = longint'(a) - longint'(b) - longint'(c);
      r.bor = (d < 0);
    end
    r.man  = N'(d);
    r.zero = (r.man == '0) && !r.ovf;
    if (LZC) begin
      r.lzc = L'(N);
      for (int i = N - 1; i >= 0; i--) begin
        if (r.man[i]) begin
          r.lzc = L'(N - 1 - i);
          break;
        end
      end
    end
    return r;
  endfunction

  function automatic res_t mk(logic [N-1:0] m, logic ov, logic bo, logic z, int lz);
    res_t r;
    r.man = m; r.ovf = ov; r.bor = bo; r.zero = z;
    r.lzc = LZC ? L'(lz) : '0;
    return r;
  endfunction

  // One clock: sample handshake and outputs mid-cycle, update the expected queue.
  task automatic tick();
    #1;
    acc       = valid & o_ready;
    fire      = o_valid & ready_in;
    cap_valid = o_valid;
    cap_ready = o_ready;
    cap       = {o_man, o_ovf, o_bor, o_zero, o_lzc};
    if (flush) q.delete();
    else if (acc) q.push_back(model(op, sa, sb, carry, mx, mn));
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    op = 1'($urandom); sa = 1'($urandom); sb = 1'($urandom); carry = 1'($urandom);
    mx = N'($urandom); mn = N'($urandom);
    if ($urandom_range(0, 7) == 0) mn = mx;
  endtask

  // Single item through an empty pipeline with i_ready held high.
  task automatic send_one(input logic fop, s_a, s_b, c, input logic [N-1:0] a, b,
                          output logic v1, output logic v2, output res_t r);
    op = fop; sa = s_a; sb = s_b; carry = c; mx = a; mn = b;
    valid = 1'b1; ready_in = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    v1 = o_valid;
    @(posedge clk); #1;
    v2 = o_valid;
    r  = {o_man, o_ovf, o_bor, o_zero, o_lzc};
    @(posedge clk); #1;
  endtask

  // Fill both stages with ready low: stage 2 holds one item, stage 1 another.
  task automatic fill_two();
    ready_in = 1'b0; valid = 1'b1;
    rand_ops(); tick();
    rand_ops(); tick();
    valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; flush = 1'b0; valid = 1'b0; ready_in = 1'b1;
    op = 0; sa = 0; sb = 0; carry = 0; mx = '0; mn = '0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      errors++; $display("FAIL reset_hs valid=%b ready=%b want 0 1", o_valid, o_ready);
    end
    checks++;
    if ({o_man, o_ovf, o_bor, o_zero, o_lzc} !== {N'(0), 1'b0, 1'b0, 1'b1, L'(0)}) begin
      errors++; $display("FAIL reset_data man=%h ovf=%b bor=%b zero=%b lzc=%0d", o_man, o_ovf, o_bor, o_zero, o_lzc);
    end
    valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (o_valid !== 1'b0) begin
      errors++; $display("FAIL reset_hold valid=%b want 0", o_valid);
    end
    valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic v1, v2;
    res_t r, e;
    send_one(0, 0, 0, 0, 24'hC00000, 24'h800000, v1, v2, r);
    e = mk(24'h400000, 1, 0, 0, 1);
    checks++;
    if (v1 !== 1'b0 || v2 !== 1'b1) begin
      errors++; $display("FAIL add_latency v1=%b v2=%b want 0 1", v1, v2);
    end
    checks++;
    if (r !== e) begin errors++; $display("FAIL add_result got %h want %h", r, e); end

    send_one(1, 0, 0, 0, 24'h800000, 24'h7FFFFF, v1, v2, r);
    e = mk(24'h000001, 0, 0, 0, 23);
    checks++;
    if (v2 !== 1'b1 || r !== e) begin
      errors++; $display("FAIL sub_result v=%b got %h want %h", v2, r, e);
    end

    send_one(0, 0, 1, 0, 24'hABCDEF, 24'hABCDEF, v1, v2, r);
    e = mk(24'h000000, 0, 0, 1, 24);
    checks++;
    if (v2 !== 1'b1 || r !== e) begin
      errors++; $display("FAIL eqsub_c0 v=%b got %h want %h", v2, r, e);
    end

    send_one(0, 0, 1, 1, 24'hABCDEF, 24'hABCDEF, v1, v2, r);
    e = mk(24'hFFFFFF, 0, 1, 0, 0);
    checks++;
    if (v2 !== 1'b1 || r !== e) begin
      errors++; $display("FAIL eqsub_c1 v=%b got %h want %h", v2, r, e);
    end

    send_one(0, 1, 1, 1, 24'h800000, 24'h800000, v1, v2, r);
    e = mk(24'h000000, 1, 0, 0, 24);
    checks++;
    if (v2 !== 1'b1 || r !== e) begin
      errors++; $display("FAIL add_carry_only v=%b got %h want %h", v2, r, e);
    end
  endtask

  task automatic test_back_to_back();
    int   nout = 0;
    res_t e;
    q.delete();
    ready_in = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      valid = (k <= 20);
      rand_ops();
      tick();
      if (k <= 20) begin
        checks++;
        if (cap_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready cyc=%0d ready=%b want 1", k, cap_ready); end
      end
      if (k >= 3 && k <= 22) begin
        checks++;
        if (cap_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid cyc=%0d valid=%b want 1", k, cap_valid); end
      end
      if (fire) begin
        nout++;
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL b2b_extra cyc=%0d got %h want none", k, cap);
        end else begin
          e = q.pop_front();
          if (cap !== e) begin errors++; $display("FAIL b2b_data cyc=%0d got %h want %h", k, cap, e); end
        end
      end
    end
    checks++;
    if (nout != 20) begin errors++; $display("FAIL b2b_count got %0d want 20", nout); end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] amx[4], amn[4];
    int   sent = 0, got = 0;
    res_t hold, e;
    q.delete();
    for (int i = 0; i < 4; i++) begin amx[i] = N'($urandom); amn[i] = N'($urandom); end
    op = 1'b1; sa = 1'b0; sb = 1'b0; carry = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      ready_in = !(k >= 3 && k <= 6);
      valid    = (sent < 4);
      if (sent < 4) begin mx = amx[sent]; mn = amn[sent]; end
      tick();
      if (acc) sent++;
      if (k == 3) hold = cap;
      if (k >= 3 && k <= 6) begin
        checks++;
        if (cap_ready !== 1'b0 || cap_valid !== 1'b1 || cap !== hold) begin
          errors++; $display("FAIL bp_stall cyc=%0d ready=%b valid=%b out=%h want 0 1 %h", k, cap_ready, cap_valid, cap, hold);
        end
      end
      if (fire) begin
        got++;
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL bp_extra cyc=%0d got %h want none", k, cap);
        end else begin
          e = q.pop_front();
          if (cap !== e) begin errors++; $display("FAIL bp_order cyc=%0d got %h want %h", k, cap, e); end
        end
      end
    end
    checks++;
    if (got != 4 || sent != 4) begin errors++; $display("FAIL bp_count got %0d sent %0d want 4 4", got, sent); end
  endtask

  task automatic test_random();
    logic pv = 1'b0;
    res_t pc = '0, e;
    int   nout = 0;
    q.delete();
    for (int k = 0; k < 400; k++) begin
      valid    = ($urandom_range(0, 3) != 0);
      ready_in = ($urandom_range(0, 3) != 0);
      rand_ops();
      tick();
      if (pv) begin
        checks++;
        if (cap_valid !== 1'b1 || cap !== pc) begin
          errors++; $display("FAIL rnd_stable cyc=%0d valid=%b got %h want %h", k, cap_valid, cap, pc);
        end
      end
      if (fire) begin
        nout++;
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rnd_extra cyc=%0d got %h want none", k, cap);
        end else begin
          e = q.pop_front();
          if (cap !== e) begin errors++; $display("FAIL rnd_data cyc=%0d got %h want %h", k, cap, e); end
        end
      end
      pv = cap_valid & ~ready_in;
      pc = cap;
    end
    valid = 1'b0; ready_in = 1'b1;
    repeat (4) begin
      tick();
      if (fire && q.size() != 0) begin
        e = q.pop_front();
        checks++;
        if (cap !== e) begin errors++; $display("FAIL rnd_drain got %h want %h", cap, e); end
      end
    end
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL rnd_lost remaining=%0d want 0", q.size()); end
  endtask

  task automatic test_flush();
    logic v1, v2;
    res_t r, e;
    q.delete();
    fill_two();
    flush = 1'b1; valid = 1'b1;
    tick();
    flush = 1'b0; valid = 1'b0; ready_in = 1'b1;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      errors++; $display("FAIL flush_clear valid=%b ready=%b want 0 1", o_valid, o_ready);
    end
    flush = 1'b1; valid = 1'b1; rand_ops();
    tick();
    flush = 1'b0; valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (cap_valid !== 1'b0) begin errors++; $display("FAIL flush_stale cyc=%0d valid=%b want 0", k, cap_valid); end
    end
    rand_ops();
    e = model(op, sa, sb, carry, mx, mn);
    send_one(op, sa, sb, carry, mx, mn, v1, v2, r);
    checks++;
    if (v1 !== 1'b0 || v2 !== 1'b1 || r !== e) begin
      errors++; $display("FAIL flush_recover v1=%b v2=%b got %h want 0 1 %h", v1, v2, r, e);
    end
  endtask

  task automatic test_reset_mid();
    logic v1, v2;
    res_t r, e;
    q.delete();
    fill_two();
    rst_n = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_zero !== 1'b1 || o_man !== '0) begin
      errors++; $display("FAIL rstmid_async valid=%b ready=%b zero=%b man=%h want 0 1 1 0", o_valid, o_ready, o_zero, o_man);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; q.delete(); ready_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (cap_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stale cyc=%0d valid=%b want 0", k, cap_valid); end
    end
    rand_ops();
    e = model(op, sa, sb, carry, mx, mn);
    send_one(op, sa, sb, carry, mx, mn, v1, v2, r);
    checks++;
    if (v1 !== 1'b0 || v2 !== 1'b1 || r !== e) begin
      errors++; $display("FAIL rstmid_recover v1=%b v2=%b got %h want 0 1 %h", v1, v2, r, e);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
